wbuffer_pp: RTL and testbench

Parametrised, double-banked write-back buffer between the OutputStage and Output-Memory. On reset it zero-fills Output-Memory. It then collects ROW_TOTAL accumulated rows per tile into one of two banks, raises LOAD_DONE, and drains the full bank to Output-Memory, one write per cycle. The other bank keeps collecting during the drain, so back-to-back coarse tiles do not stall.

---
 rtl/wbuffer_pp_if.sv | 31 +++
 rtl/wbuffer_pp.sv | 182 ++++++++++++++++++
 tb/tb_wbuffer_pp.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/wbuffer_pp_if.sv
// rtl/wbuffer_pp_if.sv - OutputStage/Output-Memory side bundle for the write-back buffer
interface wbuffer_pp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4,
  parameter int RW     = $clog2(DEPTH) + 1
);
  logic              ACC_ctrl;
  logic              CLR_DP;
  logic [RW-1:0]     ROW_TOTAL;
  logic [ADDR_W-1:0] ODST_om;
  logic              OMWrite_om;
  logic [DATA_W-1:0] DACC;
  logic              LOAD_DONE;
  logic              STORE_DONE;
  logic              INIT_DONE;
  logic              OVF_ERR;
  logic [ADDR_W-1:0] ODST_wb;
  logic              EN_wb;
  logic [DATA_W-1:0] WData_wb;

  modport master (
    output ACC_ctrl, CLR_DP, ROW_TOTAL, ODST_om, OMWrite_om, DACC,
    input  LOAD_DONE, STORE_DONE, INIT_DONE, OVF_ERR, ODST_wb, EN_wb, WData_wb
  );

  modport slave (
    input  ACC_ctrl, CLR_DP, ROW_TOTAL, ODST_om, OMWrite_om, DACC,
    output LOAD_DONE, STORE_DONE, INIT_DONE, OVF_ERR, ODST_wb, EN_wb, WData_wb
  );
endinterface

// File: rtl/wbuffer_pp.sv
// rtl/wbuffer_pp.sv - double-banked write-back buffer with zero-fill init and in-order drain
module wbuffer_pp #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4,
  parameter int RW     = $clog2(DEPTH) + 1
) (
  input  logic        CLK,
  input  logic        RSTN,
  wbuffer_pp_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int EW = ADDR_W + DATA_W;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_READY, S_STORE} state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [2][DEPTH];
  logic [RW-1:0]     wcnt_q [2];
  logic [RW-1:0]     wcnt_d [2];
  logic [1:0]        full_q, full_d;     // bank is FULL or DRAINING
  logic              fb_q, fb_d, db_q, db_d;
  logic [IW-1:0]     rcnt_q, rcnt_d;
  logic [ADDR_W-1:0] icnt_q, icnt_d;
  logic              acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              init_done_q, init_done_d;
  logic              load_q, load_d;
  logic              store_q, store_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] odst_q, odst_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [RW-1:0]     rt_eff;
  logic              cap, drop;

  // Out-of-range tile sizes fall back to a full bank
  always_comb begin
    rt_eff = bus.ROW_TOTAL;
    if (bus.ROW_TOTAL == '0 || bus.ROW_TOTAL > RW'(DEPTH)) rt_eff = RW'(DEPTH);
  end

  assign cap  = acc_q & bus.OMWrite_om & init_done_q & ~full_q[fb_q] & ~bus.CLR_DP;
  assign drop = acc_q & bus.OMWrite_om & init_done_q &  full_q[fb_q];

  // Row storage; contents are only meaningful below wcnt, so no reset needed
  always_ff @(posedge CLK) begin
    if (cap) mem_q[fb_q][wcnt_q[fb_q][IW-1:0]] <= {bus.ODST_om, bus.DACC};
  end

  // Fill side, drain FSM, and clear handling; pulses default low every cycle
  always_comb begin
    state_d     = state_q;
    wcnt_d[0]   = wcnt_q[0];
    wcnt_d[1]   = wcnt_q[1];
    full_d      = full_q;
    fb_d        = fb_q;
    db_d        = db_q;
    rcnt_d      = rcnt_q;
    icnt_d      = icnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    init_done_d = init_done_q;
    load_d      = 1'b0;
    store_d     = 1'b0;
    en_d        = 1'b0;
    odst_d      = odst_q;
    wdata_d     = wdata_q;

    if (cap) begin
      wcnt_d[fb_q] = wcnt_q[fb_q] + RW'(1);
      if (wcnt_q[fb_q] + RW'(1) == rt_eff) begin
        full_d[fb_q] = 1'b1;
        load_d       = 1'b1;
        fb_d         = ~fb_q;
      end
    end
    if (drop) ovf_d = 1'b1;

    case (state_q)
      S_INIT: begin
        en_d    = 1'b1;
        odst_d  = icnt_q;
        wdata_d = '0;
        icnt_d  = icnt_q + ADDR_W'(1);
        if (icnt_q == '1) begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (full_q[db_q]) begin
          state_d = S_READY;
          rcnt_d  = '0;
        end
      end
      default: begin
        // READY's edge already launches entry 0, so writes follow it back to back
        en_d              = 1'b1;
        {odst_d, wdata_d} = mem_q[db_q][rcnt_q];
        rcnt_d            = rcnt_q + IW'(1);
        state_d           = S_STORE;
        if (RW'(rcnt_q) == rt_eff - RW'(1)) begin
          store_d      = 1'b1;
          full_d[db_q] = 1'b0;
          wcnt_d[db_q] = '0;
          db_d         = ~db_q;
          state_d      = S_IDLE;
        end
      end
    endcase

    if (bus.CLR_DP)          acc_d = 1'b0;
    else if (bus.ACC_ctrl)   acc_d = 1'b1;
    else if (store_d && wcnt_q[fb_q] == '0) acc_d = 1'b0;

    // Datapath clear wins over everything except the zero-fill sequence
    if (bus.CLR_DP) begin
      full_d    = '0;
      fb_d      = 1'b0;
      db_d      = 1'b0;
      wcnt_d[0] = '0;
      wcnt_d[1] = '0;
      rcnt_d    = '0;
      ovf_d     = 1'b0;
      load_d    = 1'b0;
      store_d   = 1'b0;
      if (state_q != S_INIT) begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        odst_d  = odst_q;
        wdata_d = wdata_q;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_INIT;
      wcnt_q[0]   <= '0;
      wcnt_q[1]   <= '0;
      full_q      <= '0;
      fb_q        <= 1'b0;
      db_q        <= 1'b0;
      rcnt_q      <= '0;
      icnt_q      <= '0;
      acc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      init_done_q <= 1'b0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      en_q        <= 1'b0;
      odst_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q[0]   <= wcnt_d[0];
      wcnt_q[1]   <= wcnt_d[1];
      full_q      <= full_d;
      fb_q        <= fb_d;
      db_q        <= db_d;
      rcnt_q      <= rcnt_d;
      icnt_q      <= icnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      init_done_q <= init_done_d;
      load_q      <= load_d;
      store_q     <= store_d;
      en_q        <= en_d;
      odst_q      <= odst_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.LOAD_DONE  = load_q;
  assign bus.STORE_DONE = store_q;
  assign bus.INIT_DONE  = init_done_q;
  assign bus.OVF_ERR    = ovf_q;
  assign bus.ODST_wb    = odst_q;
  assign bus.EN_wb      = en_q;
  assign bus.WData_wb   = wdata_q;
endmodule

// File: tb/tb_wbuffer_pp.sv
// tb/tb_wbuffer_pp.sv - scoreboard bench for the double-banked write-back buffer
module tb_wbuffer_pp;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wbuffer_pp_if #(.DATA_W(64), .ADDR_W(4), .DEPTH(4)) bus ();

  wbuffer_pp #(.DATA_W(64), .ADDR_W(4), .DEPTH(4)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]  a;
    logic [63:0] d;
    logic        lst;
  } wr_t;

  wr_t sbq[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every Output-Memory write after INIT must match the next scoreboard entry
  always @(negedge clk) begin
    if (mon_en && rstn) begin
      if (bus.EN_wb) begin
        if (sbq.size() == 0) begin
          check("spurious_wr", bus.EN_wb, 1'b0);
        end else begin
          wr_t e;
          e = sbq.pop_front();
          check("wr_addr", bus.ODST_wb, e.a);
          check("wr_data", bus.WData_wb, e.d);
          check("wr_store_done", bus.STORE_DONE, e.lst);
        end
      end else begin
        check("store_done_no_wr", bus.STORE_DONE, 1'b0);
      end
    end
  end

  task automatic put_row(input logic [3:0] a, input logic [63:0] d, input bit exp_wr, input bit lst);
    bus.OMWrite_om = 1'b1;
    bus.ODST_om    = a;
    bus.DACC       = d;
    if (exp_wr) sbq.push_back('{a: a, d: d, lst: lst});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.OMWrite_om = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tile(input logic [2:0] rt);
    bus.ROW_TOTAL = rt;
    bus.ACC_ctrl  = 1'b1;
    @(negedge clk);
    bus.ACC_ctrl  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sbq.size(), 0);
  endtask

  // Called at a negedge with RSTN low: release and follow the zero-fill
  task automatic init_seq();
    rstn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("init_en", bus.EN_wb, 1'b1);
      check("init_addr", bus.ODST_wb, k);
      check("init_data", bus.WData_wb, 64'd0);
      check("init_done", bus.INIT_DONE, (k == 15));
    end
    @(negedge clk);
    check("init_en_after", bus.EN_wb, 1'b0);
    check("init_done_sticky", bus.INIT_DONE, 1'b1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_load"}, bus.LOAD_DONE, 1'b0);
    check({tag, "_store"}, bus.STORE_DONE, 1'b0);
    check({tag, "_initd"}, bus.INIT_DONE, 1'b0);
    check({tag, "_ovf"}, bus.OVF_ERR, 1'b0);
    check({tag, "_odst"}, bus.ODST_wb, 4'd0);
    check({tag, "_en"}, bus.EN_wb, 1'b0);
    check({tag, "_wdata"}, bus.WData_wb, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.ACC_ctrl   = 1'b0;
    bus.CLR_DP     = 1'b0;
    bus.ROW_TOTAL  = 3'd4;
    bus.ODST_om    = '0;
    bus.OMWrite_om = 1'b0;
    bus.DACC       = '0;

    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    init_seq();
    mon_en = 1'b1;

    // Single tile: LOAD_DONE right after last capture, then one idle READY cycle
    start_tile(3'd4);
    put_row(4'd3, 64'hA, 1'b1, 1'b0);
    put_row(4'd7, 64'hB, 1'b1, 1'b0);
    put_row(4'd1, 64'hC, 1'b1, 1'b0);
    put_row(4'd9, 64'hD, 1'b1, 1'b1);
    check("t1_load_done", bus.LOAD_DONE, 1'b1);
    idle(1);
    check("t1_load_pulse", bus.LOAD_DONE, 1'b0);
    check("t1_ready_gap", bus.EN_wb, 1'b0);
    wait_drain();

    // STORE_DONE left ACC_active low: a lone row is ignored without error
    bus.ROW_TOTAL = 3'd1;
    put_row(4'd5, 64'hEE, 1'b0, 1'b0);
    check("t1_acc_cleared_ld", bus.LOAD_DONE, 1'b0);
    idle(8);
    check("t1_acc_cleared_ovf", bus.OVF_ERR, 1'b0);

    // Eight back-to-back rows fill both banks; LOAD_DONE pulses four apart
    start_tile(3'd4);
    for (int i = 0; i < 8; i++) begin
      put_row(4'(i + 2), 64'h100 + 64'(i), 1'b1, (i % 4 == 3));
      if (i % 4 == 3) check("t2_load_done", bus.LOAD_DONE, 1'b1);
      else            check("t2_load_quiet", bus.LOAD_DONE, 1'b0);
    end
    idle(1);
    wait_drain();
    check("t2_no_ovf", bus.OVF_ERR, 1'b0);

    // Three two-row tiles, fill order preserved through the ping-pong
    start_tile(3'd2);
    for (int i = 0; i < 4; i++) put_row(4'(15 - i), 64'hBEEF0 + 64'(i), 1'b1, (i % 2 == 1));
    idle(2);
    for (int i = 4; i < 6; i++) put_row(4'(15 - i), 64'hBEEF0 + 64'(i), 1'b1, (i % 2 == 1));
    idle(1);
    wait_drain();
    check("t3_no_ovf", bus.OVF_ERR, 1'b0);

    // Both banks busy: extra row is dropped and flagged, CLR_DP recovers
    start_tile(3'd4);
    for (int i = 0; i < 8; i++) put_row(4'(i), 64'hC00 + 64'(i), 1'b1, (i % 4 == 3));
    put_row(4'd8, 64'hDEAD, 1'b0, 1'b0);
    check("t4_ovf_set", bus.OVF_ERR, 1'b1);
    idle(2);
    #1;
    bus.CLR_DP = 1'b1;
    sbq.delete();
    @(negedge clk);
    bus.CLR_DP = 1'b0;
    check("t4_clr_en", bus.EN_wb, 1'b0);
    check("t4_clr_ovf", bus.OVF_ERR, 1'b0);
    check("t4_clr_initd", bus.INIT_DONE, 1'b1);
    idle(4);

    // Pointers restart cleanly after the clear
    start_tile(3'd2);
    put_row(4'd6, 64'h66, 1'b1, 1'b0);
    put_row(4'd2, 64'h22, 1'b1, 1'b1);
    idle(1);
    wait_drain();

    // Asynchronous reset during STORE zeroes outputs at once and re-runs INIT
    start_tile(3'd4);
    for (int i = 0; i < 4; i++) put_row(4'(i + 10), 64'h5A0 + 64'(i), 1'b1, (i == 3));
    idle(2);
    #1;
    mon_en = 1'b0;
    rstn   = 1'b0;
    #1;
    check_zero_outputs("mid_rst");
    sbq.delete();
    @(negedge clk);
    init_seq();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
